// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing arbiter: ALU control codes, FSM states
// and the legal-opcode check.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic alu_ctrl_legal(input logic [3:0] ctrl);
        logic legal;
        legal = 1'b0;
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
            default:                                            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester, response and ALU-side signals of the shared-ALU arbiter.
// master = requesters plus ALU (environment), slave = the arbiter itself.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 4
);
    logic [NUM_REQ-1:0]        ReqValid;
    logic [NUM_REQ-1:0]        ReqReady;
    logic [NUM_REQ*CTRL_W-1:0] ReqCtrl;
    logic [NUM_REQ*DATA_W-1:0] ReqA;
    logic [NUM_REQ*DATA_W-1:0] ReqB;
    logic [NUM_REQ-1:0]        RspValid;
    logic [NUM_REQ-1:0]        RspReady;
    logic [DATA_W-1:0]         RspResult;
    logic                      RspZero;
    logic                      RspErr;
    logic [CTRL_W-1:0]         AluControl;
    logic [DATA_W-1:0]         AluA;
    logic [DATA_W-1:0]         AluB;
    logic [DATA_W-1:0]         AluResult;
    logic                      AluZero;

    modport master (
        output ReqValid, ReqCtrl, ReqA, ReqB, RspReady, AluResult, AluZero,
        input  ReqReady, RspValid, RspResult, RspZero, RspErr, AluControl, AluA, AluB
    );

    modport slave (
        input  ReqValid, ReqCtrl, ReqA, ReqB, RspReady, AluResult, AluZero,
        output ReqReady, RspValid, RspResult, RspZero, RspErr, AluControl, AluA, AluB
    );
endinterface

// File: rtl/alu_share_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first asserted request at or after
// last_grant+1 (mod N) wins.
module rr_priority_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);
    // cand_idx[k] is the requester examined k-th in this cycle's search order
    logic [IW-1:0] cand_idx [N];
    logic [N-1:0]  cand_req;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            assign cand_idx[gi] = IW'((int'(last_grant) + 1 + gi) % N);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant_any = |req;
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_req[k]) grant_idx = cand_idx[k];
        end
        grant = grant_any ? (N'(1) << grant_idx) : '0;
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one ALU among NUM_REQ requesters: round-robin accept, one EXEC
// cycle to capture the ALU output, then hold the response until the owner takes it.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 4
) (
    input logic             Clk,
    input logic             Reset,
    alu_share_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);

    state_t              state_reg;
    logic [IW-1:0]       owner_reg;
    logic [IW-1:0]       last_grant_reg;
    logic [CTRL_W-1:0]   alu_ctrl_reg;
    logic [DATA_W-1:0]   alu_a_reg;
    logic [DATA_W-1:0]   alu_b_reg;
    logic [DATA_W-1:0]   rsp_result_reg;
    logic                rsp_zero_reg;
    logic                rsp_err_reg;
    logic [NUM_REQ-1:0]  rsp_valid_reg;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;

    rr_priority_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req        (bus.ReqValid),
        .last_grant (last_grant_reg),
        .grant      (pick_grant),
        .grant_idx  (pick_idx),
        .grant_any  (pick_any)
    );

    // Acceptance is combinational so a request is taken on the edge it is seen.
    assign bus.ReqReady   = (state_reg == IDLE) ? pick_grant : '0;
    assign bus.RspValid   = rsp_valid_reg;
    assign bus.RspResult  = rsp_result_reg;
    assign bus.RspZero    = rsp_zero_reg;
    assign bus.RspErr     = rsp_err_reg;
    assign bus.AluControl = alu_ctrl_reg;
    assign bus.AluA       = alu_a_reg;
    assign bus.AluB       = alu_b_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_grant_reg <= IW'(NUM_REQ - 1);
            alu_ctrl_reg   <= CTRL_W'(ALU_ADD);
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_err_reg    <= 1'b0;
            rsp_valid_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        alu_ctrl_reg   <= bus.ReqCtrl[pick_idx*CTRL_W +: CTRL_W];
                        alu_a_reg      <= bus.ReqA[pick_idx*DATA_W +: DATA_W];
                        alu_b_reg      <= bus.ReqB[pick_idx*DATA_W +: DATA_W];
                        owner_reg      <= pick_idx;
                        last_grant_reg <= pick_idx;
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal opcodes report a forced zero result instead of ALU garbage
                    if (alu_ctrl_legal(4'(alu_ctrl_reg))) begin
                        rsp_result_reg <= bus.AluResult;
                        rsp_zero_reg   <= bus.AluZero;
                        rsp_err_reg    <= 1'b0;
                    end else begin
                        rsp_result_reg <= '0;
                        rsp_zero_reg   <= 1'b1;
                        rsp_err_reg    <= 1'b1;
                    end
                    rsp_valid_reg <= NUM_REQ'(1) << owner_reg;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (bus.RspReady[owner_reg]) begin
                        rsp_valid_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= '0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end
endmodule
